// File: rtl/uart_cmd_decoder_if.sv
// Byte stream from the UART receiver and the decoded control outputs of uart_cmd_decoder.
// The slave modport is the decoder's view; the master modport is the driving/observing side.
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic       o_run;
  logic       o_clear;
  logic       o_mode;
  logic       o_set_valid;
  logic [4:0] o_set_hour;
  logic [5:0] o_set_min;
  logic [5:0] o_set_sec;
  logic       o_err;
  logic [7:0] o_tx_data;
  logic       o_tx_start;

  modport master (
    output rx_data, rx_done, tx_busy,
    input  o_run, o_clear, o_mode, o_set_valid, o_set_hour, o_set_min, o_set_sec, o_err,
    input  o_tx_data, o_tx_start
  );

  modport slave (
    input  rx_data, rx_done, tx_busy,
    output o_run, o_clear, o_mode, o_set_valid, o_set_hour, o_set_min, o_set_sec, o_err,
    output o_tx_data, o_tx_start
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder: R/C/M single-byte commands and "T hhmmss CR" time set.
// Define UART_CMD_ECHO_EN to build the K/E acknowledge path towards the UART transmitter.
module uart_cmd_decoder (
  input  logic                  clk,
  input  logic                  rst,
  uart_cmd_decoder_if.slave     bus
);

  typedef enum logic [1:0] {StIdle, StDigit, StWaitCr} state_e;

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [3:0] digit_q [6];

  logic       run_q, clear_q, mode_q, set_valid_q, err_q;
  logic [4:0] hour_q;
  logic [5:0] min_q, sec_q;

  logic       run_ev, clear_ev, mode_ev, start_ev, digit_ev, set_ev, err_ev;
  logic       is_digit, set_ok;
  logic [6:0] hh_bin, mm_bin, ss_bin;

  assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);

  assign hh_bin = 7'(digit_q[0]) * 7'd10 + 7'(digit_q[1]);
  assign mm_bin = 7'(digit_q[2]) * 7'd10 + 7'(digit_q[3]);
  assign ss_bin = 7'(digit_q[4]) * 7'd10 + 7'(digit_q[5]);
  assign set_ok = (hh_bin <= 7'd23) && (mm_bin <= 7'd59) && (ss_bin <= 7'd59);

  always_comb begin
    run_ev   = 1'b0;
    clear_ev = 1'b0;
    mode_ev  = 1'b0;
    start_ev = 1'b0;
    digit_ev = 1'b0;
    set_ev   = 1'b0;
    err_ev   = 1'b0;
    if (bus.rx_done) begin
      unique case (state_q)
        StIdle: begin
          case (bus.rx_data)
            8'h52, 8'h72: run_ev   = 1'b1;
            8'h43, 8'h63: clear_ev = 1'b1;
            8'h4D, 8'h6D: mode_ev  = 1'b1;
            8'h54, 8'h74: start_ev = 1'b1;
            8'h0D, 8'h0A, 8'h20: ;
            default:      err_ev   = 1'b1;
          endcase
        end
        StDigit: begin
          if (is_digit) digit_ev = 1'b1;
          else          err_ev   = 1'b1;
        end
        StWaitCr: begin
          if (bus.rx_data == 8'h0D && set_ok) set_ev = 1'b1;
          else                                err_ev = 1'b1;
        end
        default: err_ev = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      for (int i = 0; i < 6; i++) digit_q[i] <= 4'd0;
      run_q       <= 1'b0;
      clear_q     <= 1'b0;
      mode_q      <= 1'b0;
      set_valid_q <= 1'b0;
      err_q       <= 1'b0;
      hour_q      <= 5'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
    end else begin
      run_q       <= run_ev;
      clear_q     <= clear_ev;
      set_valid_q <= set_ev;
      err_q       <= err_ev;
      if (mode_ev) mode_q <= ~mode_q;

      if (start_ev) begin
        cnt_q   <= 3'd0;
        state_q <= StDigit;
      end else if (digit_ev) begin
        digit_q[cnt_q] <= bus.rx_data[3:0];
        cnt_q          <= cnt_q + 3'd1;
        if (cnt_q == 3'd5) state_q <= StWaitCr;
      end else if (set_ev || (err_ev && state_q != StIdle)) begin
        state_q <= StIdle;
      end

      if (set_ev) begin
        hour_q <= hh_bin[4:0];
        min_q  <= mm_bin[5:0];
        sec_q  <= ss_bin[5:0];
      end
    end
  end

  assign bus.o_run       = run_q;
  assign bus.o_clear     = clear_q;
  assign bus.o_mode      = mode_q;
  assign bus.o_set_valid = set_valid_q;
  assign bus.o_err       = err_q;
  assign bus.o_set_hour  = hour_q;
  assign bus.o_set_min   = min_q;
  assign bus.o_set_sec   = sec_q;

`ifdef UART_CMD_ECHO_EN
  logic       ack_pending_q;
  logic [7:0] ack_byte_q;
  logic       tx_start_q;
  logic [7:0] tx_data_q;

  // A new ack lands after the send check, so it overwrites any unsent one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_pending_q <= 1'b0;
      ack_byte_q    <= 8'h00;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      if (ack_pending_q && !bus.tx_busy) begin
        tx_start_q    <= 1'b1;
        tx_data_q     <= ack_byte_q;
        ack_pending_q <= 1'b0;
      end
      if (run_ev || clear_ev || mode_ev || set_ev || err_ev) begin
        ack_pending_q <= 1'b1;
        ack_byte_q    <= err_ev ? 8'h45 : 8'h4B;
      end
    end
  end

  assign bus.o_tx_start = tx_start_q;
  assign bus.o_tx_data  = tx_data_q;
`else
  logic unused_tx_busy;
  assign unused_tx_busy = bus.tx_busy;

  assign bus.o_tx_start = 1'b0;
  assign bus.o_tx_data  = 8'h00;
`endif

endmodule
